sentinel_search_intr_slave: RTL and testbench

AXI4-Lite responder implementing the interrupt-controller register bank of the sentinel search IP, i.e. the S_AXI_INTR slave that the block-design master drives. It latches events from up to 32 internal interrupt sources, masks them with per-source and global enables, drives a single `irq` line to the processor, and clears events through a write-1-to-clear acknowledge register.

---
 rtl/sentinel_search_intr_slave.sv | 160 ++++++++++++++++
 tb/tb_sentinel_search_intr_slave.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sentinel_search_intr_slave.sv
// AXI4-Lite interrupt-controller register bank (GIE/IER/ISR/IAR/IPR) driving a single irq line.
// Optional macro SENTINEL_INTR_EDGE_EN: rising-edge event capture instead of level capture.
module sentinel_search_intr_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 1,
  parameter bit C_IRQ_ACTIVE_STATE = 1'b1
) (
  input  logic                              s_axi_intr_aclk,
  input  logic                              s_axi_intr_aresetn,
  input  logic [C_NUM_OF_INTR-1:0]          intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_intr_awaddr,
  input  logic [2:0]                        s_axi_intr_awprot,
  input  logic                              s_axi_intr_awvalid,
  output logic                              s_axi_intr_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_intr_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s_axi_intr_wstrb,
  input  logic                              s_axi_intr_wvalid,
  output logic                              s_axi_intr_wready,
  output logic [1:0]                        s_axi_intr_bresp,
  output logic                              s_axi_intr_bvalid,
  input  logic                              s_axi_intr_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_intr_araddr,
  input  logic [2:0]                        s_axi_intr_arprot,
  input  logic                              s_axi_intr_arvalid,
  output logic                              s_axi_intr_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_intr_rdata,
  output logic [1:0]                        s_axi_intr_rresp,
  output logic                              s_axi_intr_rvalid,
  input  logic                              s_axi_intr_rready,
  output logic                              irq
);

  localparam logic [31:0] INTR_MASK = (C_NUM_OF_INTR >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << C_NUM_OF_INTR) - 32'd1);
  localparam logic IRQ_ON = C_IRQ_ACTIVE_STATE;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  logic        awwready_q, awwready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gie_q, gie_d;
  logic [31:0] ier_q, ier_d;
  logic [31:0] isr_q, isr_d;
  logic        irq_q, irq_d;

  logic [31:0] src_ext, isr_set, iar_clr, strb_mask, rd_val;
  logic [2:0]  wr_sel, rd_sel;
  logic        wr_fire, rd_fire;
  logic        unused_ok;

  assign unused_ok = ^{s_axi_intr_awprot, s_axi_intr_arprot,
                       s_axi_intr_awaddr[1:0], s_axi_intr_araddr[1:0]};

  assign wr_sel  = s_axi_intr_awaddr[4:2];
  assign rd_sel  = s_axi_intr_araddr[4:2];
  assign wr_fire = awwready_q && s_axi_intr_awvalid && s_axi_intr_wvalid;
  assign rd_fire = arready_q && s_axi_intr_arvalid;

  always_comb begin
    src_ext = '0;
    src_ext[C_NUM_OF_INTR-1:0] = intr_src;
    for (int b = 0; b < 4; b++)
      strb_mask[b*8 +: 8] = {8{s_axi_intr_wstrb[b]}};
  end

`ifdef SENTINEL_INTR_EDGE_EN
  // History of the sources; an event is a 0->1 transition only.
  logic [31:0] src_q;

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) src_q <= '0;
    else                     src_q <= src_ext;
  end

  assign isr_set = src_ext & ~src_q;
`else
  assign isr_set = src_ext;
`endif

  always_comb begin
    gie_d   = gie_q;
    ier_d   = ier_q;
    iar_clr = '0;
    if (wr_fire) begin
      case (wr_sel)
        3'd0: gie_d   = s_axi_intr_wstrb[0] ? s_axi_intr_wdata[0] : gie_q;
        3'd1: ier_d   = merge_strb(ier_q, s_axi_intr_wdata, s_axi_intr_wstrb) & INTR_MASK;
        3'd3: iar_clr = s_axi_intr_wdata & strb_mask & INTR_MASK;
        default: ;
      endcase
    end
    // A new event in the same cycle as its acknowledge keeps the bit set.
    isr_d = ((isr_q & ~iar_clr) | isr_set) & INTR_MASK;
    irq_d = (gie_q && |(isr_q & ier_q)) ? IRQ_ON : ~IRQ_ON;
  end

  always_comb begin
    case (rd_sel)
      3'd0:    rd_val = {31'd0, gie_q};
      3'd1:    rd_val = ier_q;
      3'd2:    rd_val = isr_q;
      3'd4:    rd_val = isr_q & ier_q;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    awwready_d = !awwready_q && s_axi_intr_awvalid && s_axi_intr_wvalid && !bvalid_q;
    bvalid_d   = wr_fire ? 1'b1 : (s_axi_intr_bready ? 1'b0 : bvalid_q);
    arready_d  = !arready_q && s_axi_intr_arvalid && !rvalid_q;
    rvalid_d   = rd_fire ? 1'b1 : (s_axi_intr_rready ? 1'b0 : rvalid_q);
    rdata_d    = rd_fire ? rd_val : rdata_q;
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      awwready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      gie_q      <= 1'b0;
      ier_q      <= '0;
      isr_q      <= '0;
      irq_q      <= ~IRQ_ON;
    end else begin
      awwready_q <= awwready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      gie_q      <= gie_d;
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      irq_q      <= irq_d;
    end
  end

  assign s_axi_intr_awready = awwready_q;
  assign s_axi_intr_wready  = awwready_q;
  assign s_axi_intr_bvalid  = bvalid_q;
  assign s_axi_intr_bresp   = 2'b00;
  assign s_axi_intr_arready = arready_q;
  assign s_axi_intr_rvalid  = rvalid_q;
  assign s_axi_intr_rdata   = rdata_q;
  assign s_axi_intr_rresp   = 2'b00;
  assign irq                = irq_q;

endmodule

// File: tb/tb_sentinel_search_intr_slave.sv
// Directed bench for sentinel_search_intr_slave (default parameters, either capture mode).
module tb_sentinel_search_intr_slave;

`ifdef SENTINEL_INTR_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  intr_src = '0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sentinel_search_intr_slave dut (
    .s_axi_intr_aclk(clk), .s_axi_intr_aresetn(rst_n), .intr_src(intr_src),
    .s_axi_intr_awaddr(awaddr), .s_axi_intr_awprot(awprot), .s_axi_intr_awvalid(awvalid),
    .s_axi_intr_awready(awready), .s_axi_intr_wdata(wdata), .s_axi_intr_wstrb(wstrb),
    .s_axi_intr_wvalid(wvalid), .s_axi_intr_wready(wready), .s_axi_intr_bresp(bresp),
    .s_axi_intr_bvalid(bvalid), .s_axi_intr_bready(bready), .s_axi_intr_araddr(araddr),
    .s_axi_intr_arprot(arprot), .s_axi_intr_arvalid(arvalid), .s_axi_intr_arready(arready),
    .s_axi_intr_rdata(rdata), .s_axi_intr_rresp(rresp), .s_axi_intr_rvalid(rvalid),
    .s_axi_intr_rready(rready), .irq(irq)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns just after the handshake edge; bvalid is high at that point.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    do begin tick(1); n++; end while (!awready && n < 20);
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (n >= 20 || bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL write_handshake addr=%h: bvalid=%b bresp=%b waited=%0d, required bvalid=1 bresp=00",
               a, bvalid, bresp, n);
    end
  endtask

  // Returns just after rvalid rises, with the captured rdata.
  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin tick(1); n++; end while (!arready && n < 20);
    tick(1);
    arvalid = 1'b0;
    d = rdata;
    checks++;
    if (n >= 20 || rvalid !== 1'b1 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL read_handshake addr=%h: rvalid=%b rresp=%b waited=%0d, required rvalid=1 rresp=00",
               a, rvalid, rresp, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    tick(20);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got %b, required 00000", {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if (irq !== 1'b0 || rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b rdata=%h bresp=%b rresp=%b, required 0/0/00/00",
               irq, rdata, bresp, rresp);
    end
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      axi_read(5'(i * 4), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg_%0d: got %h, required 00000000", i, d);
      end
    end
  endtask

  task automatic test_irq_pulse();
    logic [31:0] d;
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h1, 4'hF);
    tick(2);
    intr_src = 1'b1;
    tick(1);
    intr_src = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b, required 0", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b, required 1", irq); end
    axi_read(5'h10, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL ipr_after_event: got %h, required 00000001", d); end
    axi_read(5'h08, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL isr_after_event: got %h, required 00000001", d); end
  endtask

  task automatic test_ack();
    logic [31:0] d;
    axi_write(5'h0C, 32'h1, 4'hF);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ack_irq_hold: got %b, required 1", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq_clear: got %b, required 0", irq); end
    axi_read(5'h10, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ack_ipr: got %h, required 00000000", d); end
    axi_read(5'h0C, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL iar_reads_zero: got %h, required 00000000", d); end
  endtask

  task automatic test_gie();
    logic [31:0] d;
    axi_write(5'h00, 32'h0, 4'hF);
    intr_src = 1'b1;
    tick(1);
    intr_src = 1'b0;
    tick(3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL gie_off_irq: got %b, required 0", irq); end
    axi_read(5'h08, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL gie_off_isr: got %h, required 00000001", d); end
    axi_read(5'h10, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL gie_off_ipr: got %h, required 00000001", d); end
    axi_write(5'h00, 32'h1, 4'hF);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL gie_on_early: got %b, required 0", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL gie_on_irq: got %b, required 1", irq); end
    axi_write(5'h0C, 32'h1, 4'hF);
    tick(2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL gie_cleanup_irq: got %b, required 0", irq); end
  endtask

  task automatic test_capture_mode();
    logic [31:0] d;
    intr_src = 1'b1;
    tick(3);
    axi_write(5'h0C, 32'h1, 4'hF);
    tick(4);
    intr_src = 1'b0;
    tick(2);
    axi_read(5'h08, d);
    checks++;
    if (d !== (EDGE ? 32'h0 : 32'h1)) begin
      errors++;
      $display("FAIL capture_mode_isr: got %h, required %h", d, EDGE ? 32'h0 : 32'h1);
    end
    axi_write(5'h0C, 32'h1, 4'hF);
    tick(2);
    axi_read(5'h08, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL capture_cleanup: isr=%h irq=%b, required 00000000/0", d, irq);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h14, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_14: got %h, required 00000000", d); end
    axi_read(5'h1C, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_1c: got %h, required 00000000", d); end
    axi_write(5'h08, 32'hFFFF_FFFF, 4'hF);
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h08, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL isr_write_ignored: got %h, required 00000000", d); end
    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h00, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL gie_upper_bits: got %h, required 00000001", d); end
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h04, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL ier_upper_bits: got %h, required 00000001", d); end
    axi_write(5'h00, 32'h0, 4'b1110);
    axi_read(5'h00, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL gie_strobe_lane0: got %h, required 00000001", d); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] d;
    bready = 1'b0;
    axi_write(5'h04, 32'h0, 4'hF);
    awaddr = 5'h04; wdata = 32'h1; wstrb = 4'h0; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        errors++;
        $display("FAIL bresp_hold_%0d: bvalid=%b awready=%b, required 1/0", i, bvalid, awready);
      end
    end
    bready = 1'b1;
    axi_write(5'h04, 32'h1, 4'h0);
    axi_read(5'h04, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ier_zero_strobe: got %h, required 00000000", d); end
    axi_write(5'h04, 32'h1, 4'b0001);
    rready = 1'b0;
    axi_read(5'h04, d);
    axi_write(5'h04, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h1) begin
        errors++;
        $display("FAIL rdata_hold_%0d: rvalid=%b rdata=%h, required 1/00000001", i, rvalid, rdata);
      end
    end
    rready = 1'b1;
    tick(1);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_release: got %b, required 0", rvalid); end
    axi_read(5'h04, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ier_after_hold: got %h, required 00000000", d); end
    axi_write(5'h04, 32'h1, 4'hF);
  endtask

  task automatic test_concurrent();
    int n = 0;
    intr_src = 1'b1;
    tick(1);
    intr_src = 1'b0;
    tick(3);
    awaddr = 5'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h08; arvalid = 1'b1;
    do begin tick(1); n++; end while (!arready && n < 20);
    checks++;
    if (awready !== 1'b1 || n >= 20) begin
      errors++;
      $display("FAIL concurrent_accept: awready=%b arready=%b, required 1/1", awready, arready);
    end
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1) begin
      errors++;
      $display("FAIL concurrent_preclear: rvalid=%b rdata=%h, required 1/00000001", rvalid, rdata);
    end
    tick(2);
    checks++;
    if (dut.s_axi_intr_bvalid !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL concurrent_clear: bvalid=%b irq=%b, required 0/0", bvalid, irq);
    end
  endtask

  task automatic test_reset_mid_transaction();
    awaddr = 5'h04; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: awready=%b wready=%b bvalid=%b irq=%b, required 0/0/0/0",
               awready, wready, bvalid, irq);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_irq_pulse();
    test_ack();
    test_gie();
    test_capture_mode();
    test_unmapped();
    test_back_pressure();
    test_concurrent();
    test_reset_mid_transaction();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion before 500000");
    $fatal(1);
  end

endmodule
